// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types for the CPU memory subsystem.
//   AW_DEF / DW_DEF : default address / data widths of the program/data memory
//   arb_state_t     : arbiter ownership state
//   port_t          : requester id, used for round-robin history and read tags
package cpu_mem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter/sequencer in front of the
// single-port synchronous program/data memory.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   a_*/b_* req,we,lock,addr,wdata  requester inputs (A = CPU, B = loader/DMA)
//   a_gnt/b_gnt                   combinational access accept
//   a_rvalid/b_rvalid, *_rdata    registered read return (rdata = mem_d_o)
//   mem_we, mem_addr, mem_d_i     memory command, zero when idle
//   mem_d_o                       memory read data, one cycle after address
//   lock_err                      one-cycle pulse when a lock is forced off
//
// state  | meaning
// ARB    | no owner, round-robin between requesters
// LOCK_A | port A owns the memory, B is held off
// LOCK_B | port B owns the memory, A is held off
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d_i,
  input  logic [DW-1:0] mem_d_o,
  output logic          lock_err
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  arb_state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  port_t      last, last_n;
  logic       err_n;
  logic       gnt_a, gnt_b;
  logic       arb_open;
  logic       resp_valid;
  port_t      resp_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      cnt        <= '0;
      last       <= PORT_B;
      lock_err   <= 1'b0;
      resp_valid <= 1'b0;
      resp_tag   <= PORT_A;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last       <= last_n;
      lock_err   <= err_n;
      resp_valid <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
      resp_tag   <= b_gnt ? PORT_B : PORT_A;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last;
    err_n    = 1'b0;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    arb_open = 1'b0;

    case (state)
      ARB: arb_open = 1'b1;
      LOCK_A: begin
        // Dropping lock hands the cycle to normal arbitration, so the
        // waiting port can be granted in the very same cycle.
        if (!a_lock) begin
          arb_open = 1'b1;
        end else begin
          gnt_a = a_req;
          if (a_req) last_n = PORT_A;
          if (cnt >= LOCK_MAX_C) begin
            state_n = ARB;
            cnt_n   = '0;
            err_n   = 1'b1;
            last_n  = PORT_A;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      LOCK_B: begin
        if (!b_lock) begin
          arb_open = 1'b1;
        end else begin
          gnt_b = b_req;
          if (b_req) last_n = PORT_B;
          if (cnt >= LOCK_MAX_C) begin
            state_n = ARB;
            cnt_n   = '0;
            err_n   = 1'b1;
            last_n  = PORT_B;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: state_n = ARB;
    endcase

    if (arb_open) begin
      state_n = ARB;
      cnt_n   = '0;
      // On a tie, the port that did not win most recently goes first.
      if (a_req && (!b_req || last == PORT_B)) gnt_a = 1'b1;
      else if (b_req)                          gnt_b = 1'b1;
      if (gnt_a) begin
        last_n = PORT_A;
        if (a_lock) begin
          state_n = LOCK_A;
          cnt_n   = 8'd1;
        end
      end
      if (gnt_b) begin
        last_n = PORT_B;
        if (b_lock) begin
          state_n = LOCK_B;
          cnt_n   = 8'd1;
        end
      end
    end
  end

  // No access is presented to the memory while reset is held.
  assign a_gnt = gnt_a & ~rst;
  assign b_gnt = gnt_b & ~rst;

  assign mem_we   = (a_gnt & a_we) | (b_gnt & b_we);
  assign mem_addr = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
  assign mem_d_i  = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);

  assign a_rvalid = resp_valid & (resp_tag == PORT_A);
  assign b_rvalid = resp_valid & (resp_tag == PORT_B);
  assign a_rdata  = mem_d_o;
  assign b_rdata  = mem_d_o;

endmodule
